// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared types and default constants for the SPI frame controller.
// Holds the controller state encoding, default command codes and conf width.
`timescale 1ns/1ps
package spi_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CONF,
        ST_DATA,
        ST_DISCARD
    } state_e;

    localparam logic [7:0] CMD_CONF_WR_DEF = 8'h2A;
    localparam logic [7:0] CMD_DATA_WR_DEF = 8'h2B;

    localparam int CONF_BYTES_DEF = 2;
    localparam int CONF_W         = 8 * CONF_BYTES_DEF;

endpackage

// File: rtl/spi_frame_ctl_cs_edge_det.sv
// cs_edge_det: registers the (already synchronous) chip select and flags
// frame start (registered cs_n falls) and frame end (registered cs_n rises).
`timescale 1ns/1ps
module cs_edge_det (
    input  logic clk_in,
    input  logic rst_in,
    input  logic cs_n_in,
    output logic frame_start_out,
    output logic frame_end_out
);

    logic cs_q;
    logic cs_prev_q;

    // Reset loads the live pin level into both stages so a transaction that
    // is already running when reset drops produces no spurious start edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cs_q      <= cs_n_in;
            cs_prev_q <= cs_n_in;
        end else begin
            cs_q      <= cs_n_in;
            cs_prev_q <= cs_q;
        end
    end

    assign frame_start_out = cs_prev_q & ~cs_q;
    assign frame_end_out   = ~cs_prev_q & cs_q;

endmodule

// File: rtl/spi_frame_ctl.sv
// spi_frame_ctl: parses chip-select-delimited SPI transactions into config
// updates and sequential pixel RAM writes. Optional macro: SPI_FRAME_CNT_EN.
`timescale 1ns/1ps
module spi_frame_ctl
    import spi_frame_pkg::*;
#(
    parameter int         ADDR_W      = 11,
    parameter int         RAM_DEPTH   = 1536,
    parameter int         CONF_BYTES  = CONF_BYTES_DEF,
    parameter logic [7:0] CMD_CONF_WR = CMD_CONF_WR_DEF,
    parameter logic [7:0] CMD_DATA_WR = CMD_DATA_WR_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    spi_cs_n_in,
    input  logic                    byte_rdy_in,
    input  logic [7:0]              byte_data_in,
    output logic                    ram_wr_en_out,
    output logic [ADDR_W-1:0]       ram_wr_addr_out,
    output logic [7:0]              ram_wr_data_out,
    output logic [8*CONF_BYTES-1:0] conf_out,
    output logic                    conf_upd_out,
    output logic                    frame_rdy_out,
    output logic                    data_ovf_out,
    output logic                    cmd_err_out
`ifdef SPI_FRAME_CNT_EN
    ,
    output logic [15:0]             frame_cnt_out
`endif
);

    localparam int CW    = 8 * CONF_BYTES;
    localparam int AW1   = ADDR_W + 1;
    localparam int CNT_W = $clog2(CONF_BYTES + 1);

    localparam logic [ADDR_W:0]  DEPTH_C   = AW1'(RAM_DEPTH);
    localparam logic [ADDR_W:0]  ADDR_ONE  = AW1'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONF_BYTES - 1);

    logic frame_start;
    logic frame_end;

    state_e state_q, state_d;

    // One extra address bit lets the counter sit at RAM_DEPTH == 2**ADDR_W.
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     shadow_q, shadow_d;
    logic [CW-1:0]     conf_q, conf_d;
    logic              conf_upd_q, conf_upd_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              frdy_q, frdy_d;
    logic              frdy_pend_q, frdy_pend_d;
    logic [CW-1:0]     shadow_shift;
    logic              data_seen;

    cs_edge_det u_cs_edge_det (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cs_n_in         (spi_cs_n_in),
        .frame_start_out (frame_start),
        .frame_end_out   (frame_end)
    );

    // First conf byte ends up in the MSBs after CONF_BYTES shifts.
    assign shadow_shift = (shadow_q << 8) | CW'(byte_data_in);

    // A data frame is worth announcing if any data byte arrived, including
    // one landing in the same cycle the frame closes.
    assign data_seen = (addr_q != '0) | ovf_q | byte_rdy_in;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: command dispatch, conf completion, frame close.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_rdy_in) begin
                    if (byte_data_in == CMD_CONF_WR) begin
                        state_d = ST_CONF;
                    end else if (byte_data_in == CMD_DATA_WR) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_CONF: begin
                if (byte_rdy_in && cnt_q == CONF_LAST) state_d = ST_DISCARD;
            end
            default: begin
            end
        endcase
        if (state_q != ST_IDLE && frame_end) state_d = ST_IDLE;
    end

    // Output/datapath decode: byte handling per state and frame-ready timing.
    always_comb begin
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        conf_d      = conf_q;
        conf_upd_d  = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        frdy_d      = frdy_pend_q;
        frdy_pend_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    addr_d = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    err_d  = 1'b0;
                end
            end
            ST_CMD: begin
                if (byte_rdy_in
                    && byte_data_in != CMD_CONF_WR
                    && byte_data_in != CMD_DATA_WR) begin
                    err_d = 1'b1;
                end
            end
            ST_CONF: begin
                if (byte_rdy_in) begin
                    shadow_d = shadow_shift;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == CONF_LAST) begin
                        conf_d     = shadow_shift;
                        conf_upd_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (byte_rdy_in) begin
                    if (addr_q < DEPTH_C) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q[ADDR_W-1:0];
                        wr_data_d = byte_data_in;
                        addr_d    = addr_q + ADDR_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // A byte closing the frame is written first; the ready
                // pulse then trails that write by one cycle.
                if (frame_end && data_seen) begin
                    if (byte_rdy_in) begin
                        frdy_pend_d = 1'b1;
                    end else begin
                        frdy_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q      <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            conf_q      <= '0;
            conf_upd_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            frdy_q      <= 1'b0;
            frdy_pend_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            conf_q      <= conf_d;
            conf_upd_q  <= conf_upd_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            frdy_q      <= frdy_d;
            frdy_pend_q <= frdy_pend_d;
        end
    end

    assign ram_wr_en_out   = wr_en_q;
    assign ram_wr_addr_out = wr_addr_q;
    assign ram_wr_data_out = wr_data_q;
    assign conf_out        = conf_q;
    assign conf_upd_out    = conf_upd_q;
    assign frame_rdy_out   = frdy_q;
    assign data_ovf_out    = ovf_q;
    assign cmd_err_out     = err_q;

`ifdef SPI_FRAME_CNT_EN
    logic [15:0] fcnt_q;

    // Completed-frame counter, stepping together with frame_rdy_out.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fcnt_q <= '0;
        end else if (frdy_d) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign frame_cnt_out = fcnt_q;
`endif

endmodule

// File: tb/tb_spi_frame_ctl.sv
// tb_spi_frame_ctl: directed bench for spi_frame_ctl with a byte-index
// reference model and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_spi_frame_ctl;

    localparam int         ADDR_W = 11;
    localparam int         DEPTH  = 4;
    localparam int         CB     = 2;
    localparam logic [7:0] CC     = 8'h2A;
    localparam logic [7:0] CD     = 8'h2B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        brdy = 1'b0;
    logic [7:0]  bdata = 8'h00;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [8*CB-1:0]   conf;
    logic              conf_upd;
    logic              frdy;
    logic              ovf;
    logic              err;
`ifdef SPI_FRAME_CNT_EN
    logic [15:0]       fcnt;
`endif

    always #5 clk = ~clk;

    spi_frame_ctl #(
        .ADDR_W    (ADDR_W),
        .RAM_DEPTH (DEPTH)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .spi_cs_n_in     (cs_n),
        .byte_rdy_in     (brdy),
        .byte_data_in    (bdata),
        .ram_wr_en_out   (wr_en),
        .ram_wr_addr_out (wr_addr),
        .ram_wr_data_out (wr_data),
        .conf_out        (conf),
        .conf_upd_out    (conf_upd),
        .frame_rdy_out   (frdy),
        .data_ovf_out    (ovf),
        .cmd_err_out     (err)
`ifdef SPI_FRAME_CNT_EN
        ,
        .frame_cnt_out   (fcnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: tracks position of each byte inside its frame.
    logic        m_cs1 = 1'b1, m_cs2 = 1'b1, m_open = 1'b0;
    int          m_n = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_sh = 16'h0;
    logic        e_wr = 1'b0, e_upd = 1'b0, e_frdy = 1'b0, e_pend = 1'b0;
    logic        e_ovf = 1'b0, e_err = 1'b0;
    int          e_addr = 0;
    logic [7:0]  e_data = 8'h00;
    logic [15:0] e_conf = 16'h0;
    logic [15:0] e_fcnt = 16'h0;

    always @(posedge clk) begin
        logic st, fe;
        int   idx;
        cyc++;
        st = m_cs2 && !m_cs1;
        fe = !m_cs2 && m_cs1;
        if (rst) begin
            m_open = 1'b0; m_n = 0;
            e_wr = 0; e_upd = 0; e_frdy = 0; e_pend = 0;
            e_ovf = 0; e_err = 0; e_addr = 0; e_data = 0;
            e_conf = 0; e_fcnt = 0;
            m_cs1 = cs_n; m_cs2 = cs_n;
        end else begin
            e_wr = 0; e_upd = 0;
            e_frdy = e_pend; e_pend = 0;
            if (!m_open) begin
                if (st) begin
                    m_open = 1'b1; m_n = 0; e_ovf = 0; e_err = 0;
                end
            end else begin
                if (brdy) begin
                    if (m_n == 0) begin
                        m_cmd = bdata;
                        if (bdata != CC && bdata != CD) e_err = 1;
                    end else if (m_cmd == CC && m_n <= CB) begin
                        m_sh = (m_sh << 8) | 16'(bdata);
                        if (m_n == CB) begin
                            e_conf = m_sh; e_upd = 1;
                        end
                    end else if (m_cmd == CD) begin
                        idx = m_n - 1;
                        if (idx < DEPTH) begin
                            e_wr = 1; e_addr = idx; e_data = bdata;
                        end else begin
                            e_ovf = 1;
                        end
                    end
                    m_n++;
                end
                if (fe) begin
                    if (m_n > 0 && m_cmd == CD && m_n > 1) begin
                        if (brdy) e_pend = 1;
                        else e_frdy = 1;
                    end
                    m_open = 1'b0;
                end
            end
            if (e_frdy) e_fcnt = e_fcnt + 16'd1;
            m_cs2 = m_cs1; m_cs1 = cs_n;
        end
    end

    // Per-cycle comparison against the model plus event tallies.
    int wq_a[$];
    int wq_d[$];
    int n_frdy = 0, n_upd = 0, last_wr_cyc = 0, last_frdy_cyc = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("wr_en", int'(wr_en), int'(e_wr));
            if (e_wr) begin
                cmp("wr_addr", int'(wr_addr), e_addr);
                cmp("wr_data", int'(wr_data), int'(e_data));
            end
            cmp("conf", int'(conf), int'(e_conf));
            cmp("conf_upd", int'(conf_upd), int'(e_upd));
            cmp("frame_rdy", int'(frdy), int'(e_frdy));
            cmp("data_ovf", int'(ovf), int'(e_ovf));
            cmp("cmd_err", int'(err), int'(e_err));
`ifdef SPI_FRAME_CNT_EN
            cmp("frame_cnt", int'(fcnt), int'(e_fcnt));
`endif
            if (wr_en) begin
                wq_a.push_back(int'(wr_addr));
                wq_d.push_back(int'(wr_data));
                last_wr_cyc = cyc;
            end
            if (frdy) begin
                n_frdy++;
                last_frdy_cyc = cyc;
            end
            if (conf_upd) n_upd++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        brdy = 1'b1; bdata = b;
        tick();
        brdy = 1'b0;
        tick();
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (3) tick();
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int w0, f0, u0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        cmp("rst_conf", int'(conf), 0);
        cmp("rst_wr_en", int'(wr_en), 0);

        // Plain data frame
        w0 = wq_a.size(); f0 = n_frdy;
        cs_low();
        send(CD); send(8'h11); send(8'h22); send(8'h33);
        cs_high();
        cmp("d_nwr", wq_a.size() - w0, 3);
        cmp("d_a0", wq_a[w0], 0);
        cmp("d_d0", wq_d[w0], 'h11);
        cmp("d_a2", wq_a[w0+2], 2);
        cmp("d_d2", wq_d[w0+2], 'h33);
        cmp("d_nfrdy", n_frdy - f0, 1);
        cmp("d_ovf", int'(ovf), 0);

        // Config frame, then an incomplete one
        u0 = n_upd;
        cs_low();
        send(CC); send(8'hA5); send(8'h5A);
        cs_high();
        cmp("c_conf", int'(conf), 'hA55A);
        cmp("c_nupd", n_upd - u0, 1);
        cs_low();
        send(CC); send(8'h77);
        cs_high();
        cmp("c2_conf", int'(conf), 'hA55A);
        cmp("c2_nupd", n_upd - u0, 1);

        // Unknown command
        w0 = wq_a.size(); f0 = n_frdy;
        cs_low();
        send(8'h3C); send(8'h01); send(8'h02);
        cs_high();
        cmp("u_err", int'(err), 1);
        cmp("u_nwr", wq_a.size() - w0, 0);
        cmp("u_nfrdy", n_frdy - f0, 0);
        cs_low();
        cmp("u_errclr", int'(err), 0);
        cs_high();

        // Overflow past DEPTH
        w0 = wq_a.size(); f0 = n_frdy;
        cs_low();
        send(CD);
        for (int i = 0; i < 6; i++) send(8'h40 + 8'(i));
        cs_high();
        cmp("o_nwr", wq_a.size() - w0, 4);
        cmp("o_alast", wq_a[w0+3], 3);
        cmp("o_dlast", wq_d[w0+3], 'h43);
        cmp("o_ovf", int'(ovf), 1);
        cmp("o_nfrdy", n_frdy - f0, 1);

        // Last byte together with cs rising
        w0 = wq_a.size(); f0 = n_frdy;
        cs_low();
        send(CD); send(8'hA1);
        brdy = 1'b1; bdata = 8'hA2; cs_n = 1'b1;
        tick();
        brdy = 1'b0;
        repeat (4) tick();
        cmp("ea_nwr", wq_a.size() - w0, 2);
        cmp("ea_dlast", wq_d[w0+1], 'hA2);
        cmp("ea_nfrdy", n_frdy - f0, 1);
        cmp("ea_gap", last_frdy_cyc - last_wr_cyc, 1);

        // Last byte coincident with internal frame end
        w0 = wq_a.size(); f0 = n_frdy;
        cs_low();
        send(CD); send(8'hB1);
        cs_n = 1'b1;
        tick();
        brdy = 1'b1; bdata = 8'hB2;
        tick();
        brdy = 1'b0;
        repeat (4) tick();
        cmp("eb_nwr", wq_a.size() - w0, 2);
        cmp("eb_dlast", wq_d[w0+1], 'hB2);
        cmp("eb_nfrdy", n_frdy - f0, 1);
        cmp("eb_gap", last_frdy_cyc - last_wr_cyc, 1);

        // Reset mid-frame
        w0 = wq_a.size(); f0 = n_frdy;
        cs_low();
        send(CD); send(8'h11); send(8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        cmp("r_conf", int'(conf), 0);
        cmp("r_err", int'(err), 0);
        send(8'h33); send(8'h44);
        cs_high();
        cmp("r_nwr", wq_a.size() - w0, 2);
        cmp("r_nfrdy", n_frdy - f0, 0);

`ifdef SPI_FRAME_CNT_EN
        for (int k = 0; k < 3; k++) begin
            cs_low();
            send(CD); send(8'h01);
            cs_high();
        end
        cmp("fcnt3", int'(fcnt), 3);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
